// File: rtl/sub_pkg.sv
// Shared definitions for the bit-serial ripple subtractor: FSM state
// encoding and the bit-counter width helper.
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bits needed to index bit positions 0..width-1 (never narrower than 1).
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit combinational full subtractor built from gate primitives.
//   D  = X ^ Y ^ Bi
//   Bo = (~X & Y) | (~(X ^ Y) & Bi)
module full_subtractor (
  output wire D,
  output wire Bo,
  input  wire X,
  input  wire Y,
  input  wire Bi
);

  wire xy_xor;
  wire xy_xnor;
  wire x_n;
  wire gen_b;
  wire prop_b;

  xor g_xor0 (xy_xor, X, Y);
  xor g_xor1 (D, xy_xor, Bi);
  not g_not0 (x_n, X);
  and g_and0 (gen_b, x_n, Y);
  not g_not1 (xy_xnor, xy_xor);
  and g_and1 (prop_b, xy_xnor, Bi);
  or  g_or0  (Bo, gen_b, prop_b);

endmodule

// File: rtl/ripple_subtractor_serial.sv
// Bit-serial subtractor: computes d = x - y - bin (mod 2^WIDTH) and the
// borrow-out one bit per clock, LSB first, through a single reused
// full_subtractor stage.
//
// Handshake: an operand set is taken on a rising edge where in_valid=1 and
// in_ready=1 (IDLE only); a result is consumed on a rising edge where
// out_valid=1 and out_ready=1 (DONE only). The producer keeps in_valid and
// operands steady until accepted; the result stays steady until consumed.
//
// Optional feature: define SUB_OVERFLOW_EN to add the signed-overflow
// output ovf.
module ripple_subtractor_serial
  import sub_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             bout,
`ifdef SUB_OVERFLOW_EN
  output logic             ovf,
`endif
  output state_t           dbg_state
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] y_q;
  logic [WIDTH-1:0] d_q;
  logic             b_q;
  logic             bout_q;
  logic [CW-1:0]    cnt;
  logic             fs_d;
  logic             fs_bo;
`ifdef SUB_OVERFLOW_EN
  logic             ovf_q;
`endif

  // The single subtractor stage looks at the bit selected by the counter.
  full_subtractor u_fs (
    .D  (fs_d),
    .Bo (fs_bo),
    .X  (x_q[cnt]),
    .Y  (y_q[cnt]),
    .Bi (b_q)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: accept in IDLE, walk WIDTH bits in RUN, wait for the
  // consumer in DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)         state_nxt = RUN;
      RUN:     if (cnt == LAST_BIT)  state_nxt = DONE;
      DONE:    if (out_ready)        state_nxt = IDLE;
      default:                       state_nxt = IDLE;
    endcase
  end

  // Datapath: latch operands on accept, then produce one difference bit and
  // the next borrow per RUN cycle; the final borrow becomes bout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q    <= '0;
      y_q    <= '0;
      d_q    <= '0;
      b_q    <= 1'b0;
      bout_q <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            x_q    <= x;
            y_q    <= y;
            b_q    <= bin;
            d_q    <= '0;
            bout_q <= 1'b0;
            cnt    <= '0;
          end
        end
        RUN: begin
          d_q[cnt] <= fs_d;
          b_q      <= fs_bo;
          cnt      <= cnt + CNT_ONE;
          if (cnt == LAST_BIT) bout_q <= fs_bo;
        end
        default: ;
      endcase
    end
  end

`ifdef SUB_OVERFLOW_EN
  // Signed overflow, captured with the MSB result as the FSM enters DONE:
  // operand signs differ and the result sign differs from the minuend sign.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      ovf_q <= 1'b0;
    end else if (state == RUN && cnt == LAST_BIT) begin
      ovf_q <= (x_q[WIDTH-1] ^ y_q[WIDTH-1]) & (fs_d ^ x_q[WIDTH-1]);
    end
  end

  assign ovf = (state == DONE) & ovf_q;
`endif

  // Outputs: partial results never leave the block; they show only in DONE.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign d         = (state == DONE) ? d_q : '0;
  assign bout      = (state == DONE) & bout_q;
  assign dbg_state = state;

endmodule

// File: doc/ripple_subtractor_serial.md
RIPPLE_SUBTRACTOR_SERIAL -- requirements
Module: ripple_subtractor_serial

Interface
REQ-001 Parameter: WIDTH, default 4, operand width in bits; legal range 2..32.
REQ-002 One clock, clk; reset is asynchronous and active-low, rst_n.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  operands x, y and bin are valid.
REQ-006 in_ready  output  1  block can accept operands.
REQ-007 x  input  WIDTH  minuend.
REQ-008 y  input  WIDTH  subtrahend.
REQ-009 bin  input  1  borrow-in.
REQ-010 out_valid  output  1  result d and bout are valid.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 d  output  WIDTH  difference, x - y - bin modulo 2^WIDTH.
REQ-013 bout  output  1  borrow-out; 1 when x < y + bin (unsigned).
REQ-014 ovf  output  1  signed overflow; present only when SUB_OVERFLOW_EN is defined.

Function
REQ-015 FSM states: IDLE, RUN and DONE; reset state is IDLE.
REQ-016 in_ready is 1 only in IDLE; out_valid is 1 only in DONE.
REQ-017 Accept: in IDLE, when in_valid=1, latch x, y and bin into internal registers, clear the bit counter to 0 and go to RUN; when in_valid=0, stay in IDLE.
REQ-018 RUN: each cycle processes bit i = counter, LSB first, through one full-subtractor stage.
- d[i] = x[i]^y[i]^b
- b_next = (~x[i]&y[i]) | (~(x[i]^y[i])&b)
- b starts at the latched bin.
REQ-019 The counter increments each RUN cycle; after the cycle with counter = WIDTH-1, bout takes the final borrow and the FSM goes to DONE.
REQ-020 Latency: out_valid rises exactly WIDTH+1 cycles after the accept cycle, independent of operand values.
REQ-021 DONE: d, bout (and ovf) are held stable while out_valid=1 and out_ready=0.
REQ-022 DONE: when out_ready=1, the result is consumed and the FSM goes to IDLE on that edge.
REQ-023 No accept in the same cycle as result delivery; minimum spacing between accepts is WIDTH+2 cycles.
REQ-024 In RUN and DONE, input changes are ignored; in_valid asserted there is not lost, because it remains pending until in_ready=1.
REQ-025 The d register bits not yet computed are undefined-but-stable only internally; the d output is 0 in IDLE and RUN and shows the result in DONE.
REQ-026 Boundary cases: x=y with bin=0 gives d=0, bout=0; x=0, y=0, bin=1 gives all-ones, bout=1; all-ones minus all-ones gives 0, bout=0.

Reset
REQ-027 On rst_n=0 asynchronously:
- state=IDLE, counter=0, operand registers=0;
- d=0, bout=0, ovf=0, out_valid=0, in_ready=1 once rst_n is released.
REQ-028 Reset asserted during RUN or DONE aborts the operation silently; no partial result is ever presented.
REQ-029 Reset deassertion is used directly; synchronising rst_n is the integrator's responsibility.

Configuration
REQ-030 Macro SUB_OVERFLOW_EN, when defined, adds port ovf.
- ovf = (x[MSB] != y[MSB]) && (d[MSB] != x[MSB]).
- Latched when entering DONE and valid alongside out_valid.
REQ-031 Without SUB_OVERFLOW_EN, the ovf port and its logic are absent; all other behaviour is identical.

Structure
REQ-032 Shared package sub_pkg holds:
- the FSM state typedef (IDLE/RUN/DONE);
- the counter width constant, $clog2(WIDTH) function form.
REQ-033 One sub-module, full_subtractor, is combinational and 1-bit, with ports (D, Bo, X, Y, Bi) built from gate primitives; it is instantiated once and reused every RUN cycle.

Verification
REQ-034 WIDTH=4: x=9, y=3, bin=0 -> d=6, bout=0; out_valid exactly 5 cycles after accept.
REQ-035 WIDTH=4: x=3, y=9, bin=0 -> d=0xA, bout=1; x=0, y=0, bin=1 -> d=0xF, bout=1.
REQ-036 Backpressure: hold out_ready=0 for 10 cycles in DONE -> d and bout stable and in_ready=0 throughout; out_ready=1 -> IDLE on the next edge.
REQ-037 Reset mid-RUN (rst_n low at counter=2) -> out_valid=0, d=0 immediately; the next operation x=15, y=15 -> d=0, bout=0.
REQ-038 With SUB_OVERFLOW_EN: x=8, y=1 -> d=7, ovf=1; x=5, y=2 -> d=3, ovf=0.
REQ-039 Exhaustive sweep of all 2^9 operand/bin combinations at WIDTH=4 against the reference model x-y-bin -> zero mismatches.
